// File: rtl/token_stream_loader_if.sv
// Token stream interface for token_stream_loader: one token (E elements of
// DATA_WIDTH bits) per beat, valid/ready handshake with an end-of-sequence flag.
interface token_stream_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int E          = 8
);
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH*E-1:0] s_data;
  logic                    s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/token_stream_loader.sv
// token_stream_loader: collects L*N tokens from a valid/ready stream into the
// flat (L,N,E) x_out vector, fires a one-cycle attn_start and holds x_out until
// attn_done. Token t = l*N + n lands at x_out[(t*E+e)*DATA_WIDTH +: DATA_WIDTH].
// Optional feature macro: LOADER_PINGPONG_EN (two banks, the shadow bank fills
// while the active bank is being processed). Default build is single-buffered.
module token_stream_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  token_stream_loader_if.slave           bus,
  output logic [DATA_WIDTH*L*N*E-1:0]    x_out,
  output logic                           attn_start,
  input  logic                           attn_done,
  output logic                           busy,
  output logic                           err_len
);

  localparam int LN = L * N;
  localparam int CW = $clog2(LN) + 1;
  localparam int TW = DATA_WIDTH * E;
  localparam int XW = TW * LN;
  localparam logic [CW-1:0] LAST_IDX = CW'(LN - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state_reg;
  logic   s_ready_reg;
  logic   attn_start_reg;

  assign bus.s_ready = s_ready_reg;
  assign attn_start  = attn_start_reg;
  assign busy        = (state_reg != ST_FILL);

`ifdef LOADER_PINGPONG_EN

  logic [XW-1:0] bank_reg [2];
  logic [CW-1:0] cnt_reg  [2];
  logic          err_reg  [2];
  logic          full_reg [2];
  logic          act_reg;

  logic fill_bank;
  logic accept;
  logic fill_last_slot;
  logic final_beat;
  logic len_bad;
  logic done_now;
  logic shadow_full_next;

  // Select which bank the incoming beat targets and derive frame-close/length flags.
  always_comb begin
    fill_bank        = (state_reg == ST_FILL) ? act_reg : ~act_reg;
    accept           = bus.s_valid && s_ready_reg;
    fill_last_slot   = (cnt_reg[fill_bank] == LAST_IDX);
    final_beat       = bus.s_last || fill_last_slot;
    len_bad          = bus.s_last != fill_last_slot;
    done_now         = (state_reg == ST_WAIT) && attn_done;
    shadow_full_next = full_reg[~act_reg] ||
                       (accept && (fill_bank != act_reg) && final_beat);
  end

  assign x_out   = bank_reg[act_reg];
  assign err_len = err_reg[act_reg];

  // Bank fill, bank swap on attn_done, and the loader state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FILL;
      s_ready_reg    <= 1'b0;
      attn_start_reg <= 1'b0;
      act_reg        <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_reg[b] <= '0;
        cnt_reg[b]  <= '0;
        err_reg[b]  <= 1'b0;
        full_reg[b] <= 1'b0;
      end
    end else begin
      attn_start_reg <= 1'b0;

      // A beat may land in the active bank (ST_FILL) or the shadow bank.
      if (accept) begin
        bank_reg[fill_bank][cnt_reg[fill_bank]*TW +: TW] <= bus.s_data;
        if (len_bad) err_reg[fill_bank] <= 1'b1;
        if (final_beat) full_reg[fill_bank] <= 1'b1;
        else            cnt_reg[fill_bank]  <= cnt_reg[fill_bank] + 1'b1;
      end

      case (state_reg)
        ST_FILL: begin
          s_ready_reg <= 1'b1;
          if (accept && final_beat) begin
            state_reg      <= ST_START;
            attn_start_reg <= 1'b1;
            s_ready_reg    <= !full_reg[~act_reg];
          end
        end
        ST_START: begin
          state_reg   <= ST_WAIT;
          s_ready_reg <= !shadow_full_next;
        end
        ST_WAIT: begin
          s_ready_reg <= !shadow_full_next;
          if (done_now) begin
            // Processed bank is released and becomes the new shadow.
            bank_reg[act_reg] <= '0;
            cnt_reg[act_reg]  <= '0;
            err_reg[act_reg]  <= 1'b0;
            full_reg[act_reg] <= 1'b0;
            act_reg           <= ~act_reg;
            s_ready_reg       <= 1'b1;
            if (shadow_full_next) begin
              state_reg      <= ST_START;
              attn_start_reg <= 1'b1;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        default: begin
          state_reg   <= ST_FILL;
          s_ready_reg <= 1'b0;
        end
      endcase
    end
  end

`else

  logic [XW-1:0] x_reg;
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  logic accept;
  logic last_slot;
  logic final_beat;
  logic len_bad;

  // Handshake and frame-close decode for the single buffer.
  always_comb begin
    accept     = bus.s_valid && s_ready_reg && (state_reg == ST_FILL);
    last_slot  = (cnt_reg == LAST_IDX);
    final_beat = bus.s_last || last_slot;
    len_bad    = bus.s_last != last_slot;
  end

  assign x_out   = x_reg;
  assign err_len = err_reg;

  // Fill, start and wait state machine with registered s_ready/attn_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_FILL;
      s_ready_reg    <= 1'b0;
      attn_start_reg <= 1'b0;
      x_reg          <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
    end else begin
      attn_start_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          s_ready_reg <= 1'b1;
          if (accept) begin
            x_reg[cnt_reg*TW +: TW] <= bus.s_data;
            if (len_bad) err_reg <= 1'b1;
            if (final_beat) begin
              // Frame closed: unwritten slots keep their cleared zero value.
              state_reg      <= ST_START;
              attn_start_reg <= 1'b1;
              s_ready_reg    <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_START: begin
          state_reg   <= ST_WAIT;
          s_ready_reg <= 1'b0;
        end
        ST_WAIT: begin
          s_ready_reg <= 1'b0;
          if (attn_done) begin
            x_reg       <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            state_reg   <= ST_FILL;
            s_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_FILL;
          s_ready_reg <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_token_stream_loader.sv
// Directed testbench for token_stream_loader (default single-buffer build).
module tb_token_stream_loader;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int N  = 1;
  localparam int E  = 8;
  localparam int TW = DW * E;
  localparam int XW = TW * L * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] x_out;
  logic          attn_start;
  logic          attn_done = 1'b0;
  logic          busy;
  logic          err_len;

  int checks = 0;
  int fails  = 0;
  int start_cnt = 0;

  token_stream_loader_if #(.DATA_WIDTH(DW), .E(E)) bus ();

  token_stream_loader #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .x_out      (x_out),
    .attn_start (attn_start),
    .attn_done  (attn_done),
    .busy       (busy),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  // Counts attn_start pulses as seen at each rising edge.
  always @(posedge clk) if (attn_start === 1'b1) start_cnt <= start_cnt + 1;

  // Token t, element e = 16'h0t0e.
  function automatic logic [TW-1:0] tok(input int t);
    logic [TW-1:0] v;
    v = '0;
    for (int e = 0; e < E; e++) v[e*DW +: DW] = {4'h0, 4'(t), 4'h0, 4'(e)};
    return v;
  endfunction

  // Expected x_out with ntok tokens starting at token value first, rest zero.
  function automatic logic [XW-1:0] frame_exp(input int first, input int ntok);
    logic [XW-1:0] v;
    v = '0;
    for (int t = 0; t < ntok; t++) v[t*TW +: TW] = tok(first + t);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int t, input bit last);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = tok(t);
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      checks++; fails++;
      $display("FAIL beat_timeout token=%0d s_ready=%b required 1", t, bus.s_ready);
    end
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    $display("beat token=%0d last=%0b cnt=%0d", t, last, dut.cnt_reg);
  endtask

  task automatic pulse_done();
    attn_done = 1'b1;
    step();
    attn_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    step(); step();
    checks++; if (x_out !== '0) begin fails++; $display("FAIL reset_x_out got=%h required 0", x_out); end
    checks++; if (dut.cnt_reg !== '0) begin fails++; $display("FAIL reset_cnt got=%0d required 0", dut.cnt_reg); end
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got=%b required 0", bus.s_ready); end
    checks++; if (attn_start !== 1'b0) begin fails++; $display("FAIL reset_attn_start got=%b required 0", attn_start); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b required 0", busy); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL reset_err_len got=%b required 0", err_len); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready got=%b required 1", bus.s_ready); end
    $display("reset done");
  endtask

  task automatic test_basic_frame();
    int s0;
    s0 = start_cnt;
    for (int t = 0; t < 8; t++) begin
      send_beat(t, t == 7);
      if (t < 7) begin
        checks++; if (attn_start !== 1'b0) begin fails++; $display("FAIL basic_early_start beat=%0d got=%b required 0", t, attn_start); end
      end
    end
    checks++; if (attn_start !== 1'b1) begin fails++; $display("FAIL basic_start got=%b required 1", attn_start); end
    checks++; if (x_out !== frame_exp(0, 8)) begin fails++; $display("FAIL basic_x_out got=%h required %h", x_out, frame_exp(0, 8)); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL basic_err_len got=%b required 0", err_len); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b required 1", busy); end
    step();
    checks++; if (attn_start !== 1'b0) begin fails++; $display("FAIL basic_start_width got=%b required 0", attn_start); end
    checks++; if (start_cnt !== s0 + 1) begin fails++; $display("FAIL basic_start_count got=%0d required %0d", start_cnt - s0, 1); end
    $display("basic frame checked");
  endtask

  task automatic test_backpressure();
    bus.s_valid = 1'b1;
    bus.s_data  = tok(9);
    bus.s_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready cycle=%0d got=%b required 0", i, bus.s_ready); end
    end
    checks++; if (x_out !== frame_exp(0, 8)) begin fails++; $display("FAIL bp_x_hold got=%h required %h", x_out, frame_exp(0, 8)); end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    pulse_done();
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_done got=%b required 1", bus.s_ready); end
    checks++; if (x_out !== '0) begin fails++; $display("FAIL bp_x_cleared got=%h required 0", x_out); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_busy got=%b required 0", busy); end
    $display("backpressure checked");
  endtask

  task automatic test_early_last();
    int s0;
    s0 = start_cnt;
    for (int t = 0; t < 4; t++) send_beat(t, t == 3);
    checks++; if (attn_start !== 1'b1) begin fails++; $display("FAIL early_start got=%b required 1", attn_start); end
    checks++; if (x_out !== frame_exp(0, 4)) begin fails++; $display("FAIL early_zero_pad got=%h required %h", x_out, frame_exp(0, 4)); end
    checks++; if (err_len !== 1'b1) begin fails++; $display("FAIL early_err_len got=%b required 1", err_len); end
    step();
    checks++; if (start_cnt !== s0 + 1) begin fails++; $display("FAIL early_start_count got=%0d required 1", start_cnt - s0); end
    pulse_done();
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL early_err_clear got=%b required 0", err_len); end
    $display("early last checked");
  endtask

  task automatic test_missing_last();
    for (int t = 0; t < 8; t++) send_beat(t, 1'b0);
    checks++; if (attn_start !== 1'b1) begin fails++; $display("FAIL missing_start got=%b required 1", attn_start); end
    checks++; if (err_len !== 1'b1) begin fails++; $display("FAIL missing_err_len got=%b required 1", err_len); end
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL missing_closed got=%b required 0", bus.s_ready); end
    step();
    pulse_done();
    send_beat(9, 1'b0);
    checks++; if (x_out !== frame_exp(9, 1)) begin fails++; $display("FAIL missing_next_slot0 got=%h required %h", x_out, frame_exp(9, 1)); end
    checks++; if (dut.cnt_reg !== 4'd1) begin fails++; $display("FAIL missing_next_cnt got=%0d required 1", dut.cnt_reg); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL missing_next_err got=%b required 0", err_len); end
    $display("missing last checked");
  endtask

  task automatic test_done_ignored();
    pulse_done();
    checks++; if (dut.cnt_reg !== 4'd1) begin fails++; $display("FAIL ignored_done_cnt got=%0d required 1", dut.cnt_reg); end
    checks++; if (x_out !== frame_exp(9, 1)) begin fails++; $display("FAIL ignored_done_x got=%h required %h", x_out, frame_exp(9, 1)); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ignored_done_busy got=%b required 0", busy); end
    $display("stray attn_done checked");
  endtask

  task automatic test_reset_mid_fill();
    int s0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 6; t++) send_beat(t, 1'b0);
    s0 = start_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (x_out !== '0) begin fails++; $display("FAIL midrst_x_out got=%h required 0", x_out); end
    checks++; if (dut.cnt_reg !== '0) begin fails++; $display("FAIL midrst_cnt got=%0d required 0", dut.cnt_reg); end
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL midrst_s_ready got=%b required 0", bus.s_ready); end
    step(); step();
    checks++; if (start_cnt !== s0) begin fails++; $display("FAIL midrst_no_start got=%0d required 0", start_cnt - s0); end
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 8; t++) send_beat(8 + t, t == 7);
    checks++; if (attn_start !== 1'b1) begin fails++; $display("FAIL midrst_frame_start got=%b required 1", attn_start); end
    checks++; if (x_out !== frame_exp(8, 8)) begin fails++; $display("FAIL midrst_frame_x got=%h required %h", x_out, frame_exp(8, 8)); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL midrst_frame_err got=%b required 0", err_len); end
    step();
    pulse_done();
    checks++; if (x_out !== '0) begin fails++; $display("FAIL midrst_done_clear got=%h required 0", x_out); end
    $display("reset mid-fill checked");
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_done_ignored();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end
endmodule
